// File: rtl/alu_output_writeback.sv
`default_nettype none
// ============================================================================
// Module   : alu_output_writeback
// Purpose  : Register-file writeback stage for the NORZ Z80-compatible
//            datapath. It applies bank swaps (EX AF / EXX / EX DE,HL), then
//            PC/R auto-increment and flag load, then the ALU result writeback.
//            Every architectural register is presented as a registered,
//            active-low bus for the ALU input mux.
// Ports    : CLK, RESET (sync, active-high)
//            Result[15:0], WB_Valid, WB_Dest[4:0]  - writeback request
//            Flag_We, Flags[7:0]                   - flag byte load
//            PC_Inc, R_Inc                         - auto-increments
//            EX_AF, EXX, EX_DEHL                   - bank / pair swaps
//            notA..notR (8b), notPC/SP/IX/IY (16b) - inverted registers
//            WB_Error                              - sticky illegal-dest flag
// Revision : 1.0 - initial release
// ============================================================================
module alu_output_writeback #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] SP_RESET = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] Result,
    input  logic        WB_Valid,
    input  logic [4:0]  WB_Dest,
    input  logic        Flag_We,
    input  logic [7:0]  Flags,
    input  logic        PC_Inc,
    input  logic        R_Inc,
    input  logic        EX_AF,
    input  logic        EXX,
    input  logic        EX_DEHL,
    output logic [7:0]  notA,
    output logic [7:0]  notF,
    output logic [7:0]  notB,
    output logic [7:0]  notC,
    output logic [7:0]  notD,
    output logic [7:0]  notE,
    output logic [7:0]  notH,
    output logic [7:0]  notL,
    output logic [7:0]  notDt,
    output logic [7:0]  notI,
    output logic [7:0]  notR,
    output logic [15:0] notPC,
    output logic [15:0] notSP,
    output logic [15:0] notIX,
    output logic [15:0] notIY,
    output logic        WB_Error
);

    // Destination codes
    localparam logic [4:0] c_DEST_A   = 5'd1;
    localparam logic [4:0] c_DEST_F   = 5'd2;
    localparam logic [4:0] c_DEST_B   = 5'd3;
    localparam logic [4:0] c_DEST_C   = 5'd4;
    localparam logic [4:0] c_DEST_D   = 5'd5;
    localparam logic [4:0] c_DEST_E   = 5'd6;
    localparam logic [4:0] c_DEST_H   = 5'd7;
    localparam logic [4:0] c_DEST_L   = 5'd8;
    localparam logic [4:0] c_DEST_DT  = 5'd9;
    localparam logic [4:0] c_DEST_I   = 5'd10;
    localparam logic [4:0] c_DEST_R   = 5'd11;
    localparam logic [4:0] c_DEST_BC  = 5'd12;
    localparam logic [4:0] c_DEST_DE  = 5'd13;
    localparam logic [4:0] c_DEST_HL  = 5'd14;
    localparam logic [4:0] c_DEST_PC  = 5'd15;
    localparam logic [4:0] c_DEST_SP  = 5'd16;
    localparam logic [4:0] c_DEST_IX  = 5'd17;
    localparam logic [4:0] c_DEST_IY  = 5'd18;
    localparam logic [4:0] c_DEST_AF  = 5'd19;
    localparam logic [4:0] c_DEST_MAX = 5'd19;

    // Architectural state (active bank, shadow bank, specials)
    logic [7:0]  r_a, r_f, r_b, r_c, r_d, r_e, r_h, r_l;
    logic [7:0]  r_a_s, r_f_s, r_b_s, r_c_s, r_d_s, r_e_s, r_h_s, r_l_s;
    logic [7:0]  r_dt, r_i, r_r;
    logic [15:0] r_pc, r_sp, r_ix, r_iy;
    logic        r_err;

    // Next-state values
    logic [7:0]  w_a, w_f, w_b, w_c, w_d, w_e, w_h, w_l;
    logic [7:0]  w_a_s, w_f_s, w_b_s, w_c_s, w_d_s, w_e_s, w_h_s, w_l_s;
    logic [7:0]  w_dt, w_i, w_r;
    logic [15:0] w_pc, w_sp, w_ix, w_iy;
    logic        w_err;

    // Active DE/HL after EXX, before EX DE,HL is applied
    logic [7:0]  w_xd, w_xe, w_xh, w_xl;

    logic        w_wb_legal;
    logic        w_wb_illegal;

    assign w_wb_legal   = WB_Valid && (WB_Dest != 5'd0) && (WB_Dest <= c_DEST_MAX);
    assign w_wb_illegal = WB_Valid && (WB_Dest > c_DEST_MAX);

    always_comb begin
        // Hold by default
        w_a_s = r_a_s;  w_f_s = r_f_s;
        w_b_s = r_b_s;  w_c_s = r_c_s;
        w_d_s = r_d_s;  w_e_s = r_e_s;
        w_h_s = r_h_s;  w_l_s = r_l_s;
        w_a   = r_a;    w_f   = r_f;
        w_b   = r_b;    w_c   = r_c;
        w_xd  = r_d;    w_xe  = r_e;
        w_xh  = r_h;    w_xl  = r_l;
        w_dt  = r_dt;   w_i   = r_i;   w_r = r_r;
        w_pc  = r_pc;   w_sp  = r_sp;
        w_ix  = r_ix;   w_iy  = r_iy;
        w_err = r_err;

        // Step 1: swaps
        if (EX_AF) begin
            w_a   = r_a_s;  w_f   = r_f_s;
            w_a_s = r_a;    w_f_s = r_f;
        end
        if (EXX) begin
            w_b   = r_b_s;  w_c   = r_c_s;
            w_xd  = r_d_s;  w_xe  = r_e_s;
            w_xh  = r_h_s;  w_xl  = r_l_s;
            w_b_s = r_b;    w_c_s = r_c;
            w_d_s = r_d;    w_e_s = r_e;
            w_h_s = r_h;    w_l_s = r_l;
        end
        // EX DE,HL operates on the bank selected after EXX
        w_d = EX_DEHL ? w_xh : w_xd;
        w_e = EX_DEHL ? w_xl : w_xe;
        w_h = EX_DEHL ? w_xd : w_xh;
        w_l = EX_DEHL ? w_xe : w_xl;

        // Step 2: auto-updates
        if (PC_Inc) begin
            w_pc = r_pc + 16'd1;
        end
        if (R_Inc) begin
            // Refresh counter: only the low 7 bits count, bit 7 is preserved
            w_r = {r_r[7], r_r[6:0] + 7'd1};
        end
        if (Flag_We) begin
            w_f = Flags;
        end

        // Step 3: writeback into the post-swap active bank
        if (w_wb_legal) begin
            case (WB_Dest)
                c_DEST_A:  w_a  = Result[7:0];
                c_DEST_F:  w_f  = Result[7:0];
                c_DEST_B:  w_b  = Result[7:0];
                c_DEST_C:  w_c  = Result[7:0];
                c_DEST_D:  w_d  = Result[7:0];
                c_DEST_E:  w_e  = Result[7:0];
                c_DEST_H:  w_h  = Result[7:0];
                c_DEST_L:  w_l  = Result[7:0];
                c_DEST_DT: w_dt = Result[7:0];
                c_DEST_I:  w_i  = Result[7:0];
                c_DEST_R:  w_r  = Result[7:0];
                c_DEST_BC: begin w_b = Result[15:8]; w_c = Result[7:0]; end
                c_DEST_DE: begin w_d = Result[15:8]; w_e = Result[7:0]; end
                c_DEST_HL: begin w_h = Result[15:8]; w_l = Result[7:0]; end
                c_DEST_PC: w_pc = Result;
                c_DEST_SP: w_sp = Result;
                c_DEST_IX: w_ix = Result;
                c_DEST_IY: w_iy = Result;
                c_DEST_AF: begin w_a = Result[15:8]; w_f = Result[7:0]; end
                default:   ;
            endcase
        end

        if (w_wb_illegal) begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_a   <= 8'hFF;  r_f   <= 8'hFF;
            r_a_s <= 8'hFF;  r_f_s <= 8'hFF;
            r_b   <= 8'h00;  r_c   <= 8'h00;
            r_d   <= 8'h00;  r_e   <= 8'h00;
            r_h   <= 8'h00;  r_l   <= 8'h00;
            r_b_s <= 8'h00;  r_c_s <= 8'h00;
            r_d_s <= 8'h00;  r_e_s <= 8'h00;
            r_h_s <= 8'h00;  r_l_s <= 8'h00;
            r_dt  <= 8'h00;  r_i   <= 8'h00;  r_r <= 8'h00;
            r_pc  <= PC_RESET;
            r_sp  <= SP_RESET;
            r_ix  <= 16'h0000;
            r_iy  <= 16'h0000;
            r_err <= 1'b0;
        end else begin
            r_a   <= w_a;    r_f   <= w_f;
            r_a_s <= w_a_s;  r_f_s <= w_f_s;
            r_b   <= w_b;    r_c   <= w_c;
            r_d   <= w_d;    r_e   <= w_e;
            r_h   <= w_h;    r_l   <= w_l;
            r_b_s <= w_b_s;  r_c_s <= w_c_s;
            r_d_s <= w_d_s;  r_e_s <= w_e_s;
            r_h_s <= w_h_s;  r_l_s <= w_l_s;
            r_dt  <= w_dt;   r_i   <= w_i;   r_r <= w_r;
            r_pc  <= w_pc;
            r_sp  <= w_sp;
            r_ix  <= w_ix;
            r_iy  <= w_iy;
            r_err <= w_err;
        end
    end

    // Outputs are pure inversions of flop contents
    assign notA     = ~r_a;
    assign notF     = ~r_f;
    assign notB     = ~r_b;
    assign notC     = ~r_c;
    assign notD     = ~r_d;
    assign notE     = ~r_e;
    assign notH     = ~r_h;
    assign notL     = ~r_l;
    assign notDt    = ~r_dt;
    assign notI     = ~r_i;
    assign notR     = ~r_r;
    assign notPC    = ~r_pc;
    assign notSP    = ~r_sp;
    assign notIX    = ~r_ix;
    assign notIY    = ~r_iy;
    assign WB_Error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_output_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_output_writeback
// Purpose  : Self-checking bench for alu_output_writeback. A table of
//            sequential {inputs, observed output, expected value} records is
//            applied one clock per entry; reset behaviour is checked by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_output_writeback;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] Result;
    logic        WB_Valid;
    logic [4:0]  WB_Dest;
    logic        Flag_We;
    logic [7:0]  Flags;
    logic        PC_Inc;
    logic        R_Inc;
    logic        EX_AF;
    logic        EXX;
    logic        EX_DEHL;
    logic [7:0]  notA, notF, notB, notC, notD, notE, notH, notL, notDt, notI, notR;
    logic [15:0] notPC, notSP, notIX, notIY;
    logic        WB_Error;

    alu_output_writeback #(
        .PC_RESET(16'h0000),
        .SP_RESET(16'hFFFF)
    ) dut (
        .CLK(CLK), .RESET(RESET), .Result(Result), .WB_Valid(WB_Valid),
        .WB_Dest(WB_Dest), .Flag_We(Flag_We), .Flags(Flags), .PC_Inc(PC_Inc),
        .R_Inc(R_Inc), .EX_AF(EX_AF), .EXX(EXX), .EX_DEHL(EX_DEHL),
        .notA(notA), .notF(notF), .notB(notB), .notC(notC), .notD(notD),
        .notE(notE), .notH(notH), .notL(notL), .notDt(notDt), .notI(notI),
        .notR(notR), .notPC(notPC), .notSP(notSP), .notIX(notIX),
        .notIY(notIY), .WB_Error(WB_Error)
    );

    always #5 CLK = ~CLK;

    // Output selectors
    localparam int c_A = 0, c_F = 1, c_B = 2, c_C = 3, c_D = 4, c_E = 5,
                   c_H = 6, c_L = 7, c_DT = 8, c_I = 9, c_R = 10, c_PC = 11,
                   c_SP = 12, c_IX = 13, c_IY = 14, c_ERR = 15;

    typedef struct {
        logic        valid;
        logic [4:0]  dest;
        logic [15:0] result;
        logic        fwe;
        logic [7:0]  flags;
        logic        pci;
        logic        ri;
        logic        exaf;
        logic        exx;
        logic        dehl;
        int          chk;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] d,
                                input logic [15:0] res, input logic fwe,
                                input logic [7:0] fl, input logic pci,
                                input logic ri, input logic exaf,
                                input logic exx, input logic dehl,
                                input int chk, input logic [15:0] exp);
        vec_t t;
        t.valid = v;  t.dest = d;   t.result = res; t.fwe = fwe;
        t.flags = fl; t.pci = pci;  t.ri = ri;      t.exaf = exaf;
        t.exx = exx;  t.dehl = dehl; t.chk = chk;   t.exp = exp;
        return t;
    endfunction

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            c_A:   return {8'h00, notA};
            c_F:   return {8'h00, notF};
            c_B:   return {8'h00, notB};
            c_C:   return {8'h00, notC};
            c_D:   return {8'h00, notD};
            c_E:   return {8'h00, notE};
            c_H:   return {8'h00, notH};
            c_L:   return {8'h00, notL};
            c_DT:  return {8'h00, notDt};
            c_I:   return {8'h00, notI};
            c_R:   return {8'h00, notR};
            c_PC:  return notPC;
            c_SP:  return notSP;
            c_IX:  return notIX;
            c_IY:  return notIY;
            default: return {15'h0000, WB_Error};
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Result = 16'h0000; WB_Valid = 1'b0; WB_Dest = 5'd0;
        Flag_We = 1'b0; Flags = 8'h00; PC_Inc = 1'b0; R_Inc = 1'b0;
        EX_AF = 1'b0; EXX = 1'b0; EX_DEHL = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();

        // ---- reset and idle ------------------------------------------------
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_notA",  {8'h00, notA}, 16'h0000);
        check("reset_notF",  {8'h00, notF}, 16'h0000);
        check("reset_notB",  {8'h00, notB}, 16'h00FF);
        check("reset_notPC", notPC, 16'hFFFF);
        check("reset_notSP", notSP, 16'h0000);
        check("reset_notR",  {8'h00, notR}, 16'h00FF);
        check("reset_notIX", notIX, 16'hFFFF);
        check("reset_err",   {15'h0000, WB_Error}, 16'h0000);

        // ---- sequential vector table --------------------------------------
        //             valid dest    result    fwe flags pci ri  exaf exx dehl chk   exp
        vecs.push_back(mk(1, 5'd12, 16'h1234, 0, 8'h00, 0, 0, 0, 0, 0, c_B,  16'h00ED));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_C,  16'h00CB));
        vecs.push_back(mk(1, 5'd3,  16'h00AB, 0, 8'h00, 0, 0, 0, 0, 0, c_B,  16'h0054));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_C,  16'h00CB));
        vecs.push_back(mk(1, 5'd15, 16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0, c_PC, 16'h0000));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 1, 0, 0, 0, 0, c_PC, 16'hFFFF));
        vecs.push_back(mk(1, 5'd15, 16'h4000, 0, 8'h00, 1, 0, 0, 0, 0, c_PC, 16'hBFFF));
        vecs.push_back(mk(1, 5'd11, 16'h007F, 0, 8'h00, 0, 0, 0, 0, 0, c_R,  16'h0080));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 1, 0, 0, 0, c_R,  16'h00FF));
        vecs.push_back(mk(1, 5'd11, 16'h00FF, 0, 8'h00, 0, 0, 0, 0, 0, c_R,  16'h0000));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 1, 0, 0, 0, c_R,  16'h007F));
        vecs.push_back(mk(1, 5'd11, 16'h0055, 0, 8'h00, 0, 1, 0, 0, 0, c_R,  16'h00AA));
        vecs.push_back(mk(1, 5'd14, 16'h1111, 0, 8'h00, 0, 0, 0, 0, 0, c_H,  16'h00EE));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 1, 0, c_H,  16'h00FF));
        vecs.push_back(mk(1, 5'd14, 16'h2222, 0, 8'h00, 0, 0, 0, 0, 0, c_L,  16'h00DD));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 1, 0, c_H,  16'h00EE));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_L,  16'h00EE));
        // Build DE'=AAAA, HL'=BBBB, then EXX+EX_DEHL together
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 1, 0, c_H,  16'h00DD));
        vecs.push_back(mk(1, 5'd13, 16'hAAAA, 0, 8'h00, 0, 0, 0, 0, 0, c_D,  16'h0055));
        vecs.push_back(mk(1, 5'd14, 16'hBBBB, 0, 8'h00, 0, 0, 0, 0, 0, c_L,  16'h0044));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 1, 0, c_D,  16'h00FF));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 1, 1, c_D,  16'h0044));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_H,  16'h0055));
        // AF write beats Flag_We; then plain Flag_We; then EX AF round trip
        vecs.push_back(mk(1, 5'd19, 16'h1234, 1, 8'h81, 0, 0, 0, 0, 0, c_F,  16'h00CB));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_A,  16'h00ED));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 1, 8'h81, 0, 0, 0, 0, 0, c_F,  16'h007E));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 1, 0, 0, c_A,  16'h0000));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 1, 0, 0, c_F,  16'h007E));
        // Remaining destinations
        vecs.push_back(mk(1, 5'd16, 16'h1357, 0, 8'h00, 0, 0, 0, 0, 0, c_SP, 16'hECA8));
        vecs.push_back(mk(1, 5'd17, 16'hABCD, 0, 8'h00, 0, 0, 0, 0, 0, c_IX, 16'h5432));
        vecs.push_back(mk(1, 5'd18, 16'h0F0F, 0, 8'h00, 0, 0, 0, 0, 0, c_IY, 16'hF0F0));
        vecs.push_back(mk(1, 5'd9,  16'h125A, 0, 8'h00, 0, 0, 0, 0, 0, c_DT, 16'h00A5));
        vecs.push_back(mk(1, 5'd10, 16'h00C3, 0, 8'h00, 0, 0, 0, 0, 0, c_I,  16'h003C));
        vecs.push_back(mk(1, 5'd6,  16'h00E1, 0, 8'h00, 0, 0, 0, 0, 0, c_E,  16'h001E));
        vecs.push_back(mk(1, 5'd2,  16'h0099, 0, 8'h00, 0, 0, 0, 0, 0, c_F,  16'h0066));
        // No-write cases: code 0 and WB_Valid low
        vecs.push_back(mk(1, 5'd0,  16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0, c_E,  16'h001E));
        vecs.push_back(mk(0, 5'd1,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_A,  16'h00ED));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_ERR,16'h0000));
        // Illegal codes: sticky error, no register change
        vecs.push_back(mk(1, 5'd25, 16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0, c_ERR,16'h0001));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_A,  16'h00ED));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_ERR,16'h0001));
        vecs.push_back(mk(1, 5'd20, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_SP, 16'hECA8));
        vecs.push_back(mk(1, 5'd31, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_PC, 16'hBFFF));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, c_ERR,16'h0001));

        foreach (vecs[i]) begin
            WB_Valid = vecs[i].valid;  WB_Dest = vecs[i].dest;
            Result   = vecs[i].result; Flag_We = vecs[i].fwe;
            Flags    = vecs[i].flags;  PC_Inc  = vecs[i].pci;
            R_Inc    = vecs[i].ri;     EX_AF   = vecs[i].exaf;
            EXX      = vecs[i].exx;    EX_DEHL = vecs[i].dehl;
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_sel%0d", i, vecs[i].chk), observe(vecs[i].chk), vecs[i].exp);
        end

        // ---- reset overrides a simultaneous write and swaps ----------------
        RESET = 1'b1; WB_Valid = 1'b1; WB_Dest = 5'd19; Result = 16'h5A5A;
        EXX = 1'b1; EX_AF = 1'b1; PC_Inc = 1'b1; Flag_We = 1'b1; Flags = 8'h3C;
        @(posedge CLK);
        #1;
        idle_inputs();
        RESET = 1'b0;
        check("rst_ovr_notA",  {8'h00, notA}, 16'h0000);
        check("rst_ovr_notF",  {8'h00, notF}, 16'h0000);
        check("rst_ovr_notH",  {8'h00, notH}, 16'h00FF);
        check("rst_ovr_notPC", notPC, 16'hFFFF);
        check("rst_ovr_notSP", notSP, 16'h0000);
        check("rst_ovr_notIY", notIY, 16'hFFFF);
        check("rst_ovr_err",   {15'h0000, WB_Error}, 16'h0000);

        // Shadow bank restored by reset: EX AF exposes A'=F'=FF
        EX_AF = 1'b1;
        @(posedge CLK);
        #1;
        EX_AF = 1'b0;
        check("rst_shadow_notA", {8'h00, notA}, 16'h0000);

        // PC_Inc after reset counts from PC_RESET
        PC_Inc = 1'b1;
        @(posedge CLK);
        #1;
        PC_Inc = 1'b0;
        check("pc_inc_from_reset", notPC, 16'hFFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_output_writeback.md
# alu_output_writeback

Register-file writeback stage for the NORZ Z80-compatible datapath: the other end of the ALU operand path. It takes the 16-bit ALU result plus a destination code and writes it into the architectural registers. It also applies flag updates, PC/R auto-increment and the EX/EXX bank swaps. It presents every register as the registered, active-low `not*` buses that the ALU input mux consumes.

## Interface
Parameters:
- `PC_RESET`, 16'h0000, PC value loaded on reset.
- `SP_RESET`, 16'hFFFF, SP value loaded on reset.

Ports:
- `CLK`  in  1  the single clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `Result`  in  16  ALU result; 8-bit destinations take `Result[7:0]`; pairs take `[15:8]`→high register, `[7:0]`→low register.
- `WB_Valid`  in  1  qualifies `WB_Dest`/`Result` this cycle.
- `WB_Dest`  in  5  destination code: 0 none, 1 A, 2 F, 3 B, 4 C, 5 D, 6 E, 7 H, 8 L, 9 Dt, 10 I, 11 R, 12 BC, 13 DE, 14 HL, 15 PC, 16 SP, 17 IX, 18 IY, 19 AF; 20–31 illegal.
- `Flag_We`  in  1  load `Flags` into F.
- `Flags`  in  8  new flag byte from ALU.
- `PC_Inc`  in  1  PC ← PC+1.
- `R_Inc`  in  1  R[6:0] ← R[6:0]+1 (refresh).
- `EX_AF`  in  1  swap AF with AF'.
- `EXX`  in  1  swap BC/DE/HL with BC'/DE'/HL'.
- `EX_DEHL`  in  1  swap active DE and HL.
- `notA, notF, notB, notC, notD, notE, notH, notL, notDt, notI, notR`  out  8 each  inverted active-bank register contents.
- `notPC, notSP, notIX, notIY`  out  16 each  inverted 16-bit registers.
- `WB_Error`  out  1  sticky: an illegal `WB_Dest` was seen with `WB_Valid`.

## Operation
- State: A,F,B,C,D,E,H,L, shadow A',F',B',C',D',E',H',L', Dt, I, R (8 bit); PC, SP, IX, IY (16 bit); `WB_Error`.
- Outputs are the bitwise inverse of the active registers, driven directly from flops with no combinational path from inputs.
- Per-edge evaluation order; later steps override earlier steps for the same register:
  1. Swaps. `EX_AF` exchanges AF↔AF'. `EXX` exchanges BC,DE,HL↔primed. `EX_DEHL` exchanges active DE↔HL after `EXX`, so with both asserted the result is DE←old HL', HL←old DE'.
  2. Auto-updates. `PC_Inc`: PC+1 mod 2^16, FFFF→0000. `R_Inc`: R[6:0] wraps 7F→00 with R[7] unchanged. `Flag_We`: F←`Flags`.
  3. Writeback. If `WB_Valid` and the code is legal, the destination is loaded from `Result` into the post-swap active bank.
- Writeback wins over auto-updates: a PC write beats `PC_Inc`, an R write beats `R_Inc`, and an F or AF write beats `Flag_We`.
- Code 0, or `WB_Valid`=0: no write.
- Illegal code with `WB_Valid`=1: no register changes, `WB_Error`←1. The error flag holds until `RESET`.
- Shadow registers are never directly written; they change only via swaps.

## Timing
- Latency: a write, increment or swap presented in cycle N is visible on the `not*` outputs in cycle N+1. There is no read bypass.
- Throughput: one write plus any combination of auto-updates and swaps per cycle. There is no handshake or backpressure.
- Reset, when `RESET`=1 at an edge:
  - A=F=FF, A'=F'=FF; all other 8-bit registers (active and shadow), Dt, I, R = 00; IX=IY=0000; PC=`PC_RESET`; SP=`SP_RESET`; `WB_Error`=0.
  - Resulting outputs: notA=notF=00, notB..notL=FF, notDt=notI=notR=FF, notIX=notIY=FFFF, notPC=FFFF (default), notSP=0000 (default).
- `RESET` overrides every other input in the same cycle, including a simultaneous write or swap.

## Test plan
- Reset, then idle 2 cycles → notA=00, notF=00, notB=FF, notPC=FFFF, notSP=0000, notR=FF, `WB_Error`=0.
- `WB_Dest`=12 (BC), `Result`=1234, then `WB_Dest`=3 (B), `Result`=00AB → cycle after first write: notB=ED, notC=CB; after second: notB=54, notC=CB.
- PC=FFFF with `PC_Inc`=1 → PC=0000. Next cycle `PC_Inc`=1 together with a write of PC=4000 → PC=4000.
- R=7F with `R_Inc` → R=00. R=FF with `R_Inc` → R=80. `R_Inc` with a write of R=55 → R=55.
- Write HL=1111, then `EXX`, then write HL=2222, then `EXX` → notH/notL show EE/EE. Same cycle `EXX`+`EX_DEHL` with DE'=AAAA, HL'=BBBB → DE=BBBB, HL=AAAA.
- `WB_Valid`=1, `WB_Dest`=25, `Result`=FFFF → no register changes, `WB_Error`=1 and held until `RESET`. `Flag_We` with `Flags`=81 in the same cycle as an AF write of 1234 → F=34.
